bytecode_fetcher: RTL and testbench
===================================

Name: bytecode_fetcher

Overview:
- Producer end of the bytecode byte stream consumed by the JIT translation state machine.
- Prefetches JVM method bytecode from a byte-wide instruction memory with variable read latency into a small FIFO.
- Presents the head byte on iram_data and asserts waiting while no byte is available.
- Supports branch redirect with flush and end-of-method detection.

Parameters:
ADR_W, 16, bytecode address width
DEPTH, 4, prefetch FIFO depth in bytes (power of 2, >=2)
MAX_OUT, 2, maximum outstanding memory reads (<= DEPTH)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high; one clock; clears all state
start  input  1  one-cycle pulse: begin fetching a method
start_adr  input  ADR_W  first bytecode address, sampled on start
end_adr  input  ADR_W  one past last bytecode address, sampled on start
redirect  input  1  one-cycle pulse: branch taken, flush and refetch
redirect_adr  input  ADR_W  branch target, sampled on redirect
take  input  1  consumer pops head byte this cycle
iram_data  output  8  head byte of FIFO (0 when empty)
byte_adr  output  ADR_W  address of head byte
waiting  output  1  1 = no valid head byte; consumer must stall
done  output  1  method fully fetched and consumed
mem_rd  output  1  read request pulse; memory always accepts
mem_adr  output  ADR_W  read address, valid with mem_rd
mem_data  input  8  read data
mem_valid  input  1  read data valid; responses return in order, latency >=1

Behaviour:
- Reset values: state=IDLE, FIFO empty, outstanding=0, discard=0, iram_data=0, byte_adr=0, waiting=1, done=0, mem_rd=0, mem_adr=0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + start -> RUN. Load fetch_adr and byte_adr from start_adr, latch end_adr, clear FIFO, done<=0. start in RUN/FLUSH is ignored.
- Issue rule in RUN: mem_rd=1 when fetch_adr<end_adr, outstanding<MAX_OUT and outstanding+fifo_count<DEPTH (credit guarantees no FIFO overflow).
  - mem_adr=fetch_adr; fetch_adr increments next cycle.
  - At most one request per cycle; mem_rd is registered.
- mem_valid with discard=0: push mem_data. outstanding decrements; it also increments if mem_rd is issued the same cycle (net 0).
- waiting = !(state==RUN && fifo_count>0), combinational from registered state.
- take while waiting=0: pop, byte_adr+1. take while waiting=1 is ignored. Simultaneous push and pop is allowed at any fill level, including empty→one-cycle bypass not required (push visible the cycle after).
- redirect in RUN (priority over take same cycle):
  - clear FIFO; fetch_adr and byte_adr <= redirect_adr.
  - discard <= outstanding minus any response arriving that cycle; no mem_rd that cycle.
  - discard>0 -> FLUSH, else stay RUN.
- FLUSH: no mem_rd. Each mem_valid decrements discard and outstanding, with data dropped. discard reaching 0 -> RUN next cycle. redirect in FLUSH reloads the addresses; discard stays equal to outstanding.
- redirect in IDLE/DONE is ignored.
- RUN -> DONE when fetch_adr>=end_adr, outstanding=0, FIFO empty, no redirect. done=1 in DONE. Covers redirect_adr>=end_adr.
- Empty method (start_adr==end_adr): RUN one cycle, then DONE; no mem_rd.
- Address arithmetic wraps modulo 2^ADR_W. No special case; end_adr must be reachable.
- reset mid-operation: all state cleared immediately. Late mem_valid after reset is ignored (outstanding=0, IDLE).

Test Plan:
- Reset then idle: waiting=1, done=0, mem_rd never asserted over 20 cycles.
- start_adr=0x10, end_adr=0x14, memory returns 0x2A,0x10,0x3C,0xB1 with latency 1, take held high → bytes consumed in order with byte_adr 0x10..0x13. mem_rd count is exactly 4. done=1 after last pop.
- Same method, take low, memory latency 3 → at most 2 outstanding, FIFO fills to 4, then mem_rd stops. Releasing take drains in order with no loss or duplication.
- Redirect to 0x40 with 2 reads outstanding → state FLUSH, next 2 mem_valid data dropped. First byte presented is mem[0x40] with byte_adr=0x40.
- redirect and take asserted in the same cycle with FIFO holding 3 bytes → FIFO empty afterwards, byte_adr=redirect_adr, no pop side effect.
- start_adr==end_adr=0x20 → no mem_rd, done=1 within 2 cycles. Reset asserted mid-RUN → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/bytecode_fetcher.sv
// bytecode_fetcher
//   Producer end of the bytecode stream feeding the JIT translation FSM.
//   Prefetches method bytecode from a byte-wide instruction memory into a
//   small FIFO. Reads may take a variable number of cycles, but responses
//   always return in order. The head byte is presented on iram_data while
//   waiting is low. Branch redirects flush the FIFO and drop the responses
//   that are still in flight.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               pulse: begin a method at start_adr, ending before end_adr
//   redirect            pulse: branch taken, refetch from redirect_adr
//   take                consumer pops the head byte this cycle
//   iram_data/byte_adr  head byte and its address
//   waiting             no valid head byte; consumer must stall
//   done                method fully fetched and consumed
//   mem_rd/mem_adr      registered read request to instruction memory
//   mem_data/mem_valid  in-order read response, latency >= 1
module bytecode_fetcher #(
    parameter int ADR_W   = 16,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADR_W-1:0] start_adr,
    input  logic [ADR_W-1:0] end_adr,
    input  logic             redirect,
    input  logic [ADR_W-1:0] redirect_adr,
    input  logic             take,
    output logic [7:0]       iram_data,
    output logic [ADR_W-1:0] byte_adr,
    output logic             waiting,
    output logic             done,
    output logic             mem_rd,
    output logic [ADR_W-1:0] mem_adr,
    input  logic [7:0]       mem_data,
    input  logic             mem_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [ADR_W-1:0] fetch_adr;
    logic [ADR_W-1:0] end_adr_q;
    logic [7:0]       fifo [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] discard_nxt;
    logic [CNT_W:0]   credit;

    logic             resp;
    logic             issue;
    logic             push;
    logic             pop;
    logic             load_start;
    logic             reload;

    // A response only counts if a read is actually in flight; anything
    // arriving after reset or while idle is ignored.
    assign resp   = mem_valid && (outstanding != '0);

    // Bytes already in the FIFO plus bytes still on their way. Keeping this
    // below DEPTH means every response has a slot waiting for it.
    assign credit = {1'b0, outstanding} + {1'b0, count};

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        load_start  = 1'b0;
        reload      = 1'b0;
        discard_nxt = discard;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load_start = 1'b1;
                    state_nxt  = S_RUN;
                end
            end

            S_RUN: begin
                if (redirect) begin
                    // Redirect wins over take; a response landing this cycle
                    // belongs to the old path and is dropped right here.
                    reload      = 1'b1;
                    discard_nxt = outstanding - CNT_W'(resp);
                    if (discard_nxt != '0) begin
                        state_nxt = S_FLUSH;
                    end
                end else begin
                    push  = resp;
                    pop   = take && (count != '0);
                    issue = (fetch_adr < end_adr_q)
                         && (outstanding < CNT_W'(MAX_OUT))
                         && (credit < (CNT_W+1)'(DEPTH));
                    if ((fetch_adr >= end_adr_q) && (outstanding == '0)
                        && (count == '0)) begin
                        state_nxt = S_DONE;
                    end
                end
            end

            S_FLUSH: begin
                // discard tracks outstanding exactly here, so a second
                // redirect only needs to move the addresses.
                reload      = redirect;
                discard_nxt = discard - CNT_W'(resp);
                if (discard_nxt == '0) begin
                    state_nxt = S_RUN;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            fetch_adr   <= '0;
            end_adr_q   <= '0;
            byte_adr    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            mem_rd      <= 1'b0;
            mem_adr     <= '0;
        end else begin
            state       <= state_nxt;
            mem_rd      <= issue;
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
            discard     <= discard_nxt;
            if (issue) begin
                mem_adr <= fetch_adr;
            end

            if (load_start) begin
                fetch_adr <= start_adr;
                byte_adr  <= start_adr;
                end_adr_q <= end_adr;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
            end else if (reload) begin
                fetch_adr <= redirect_adr;
                byte_adr  <= redirect_adr;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
            end else begin
                if (issue) begin
                    fetch_adr <= fetch_adr + ADR_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    byte_adr <= byte_adr + ADR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage carries no reset; occupancy is governed by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= mem_data;
        end
    end

    assign waiting   = !((state == S_RUN) && (count != '0));
    assign iram_data = waiting ? 8'h00 : fifo[rd_ptr];
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_bytecode_fetcher.sv
// tb_bytecode_fetcher
//   Self-checking bench for bytecode_fetcher. An in-order memory with
//   configurable latency answers reads. The reference model is the expected
//   byte stream: every popped byte must be the next address of the current
//   path with that address's memory contents, and every read must target the
//   next fetch address of the path. Both paths restart at start/redirect.
module tb_bytecode_fetcher;

    localparam int ADR_W   = 16;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [ADR_W-1:0] start_adr;
    logic [ADR_W-1:0] end_adr;
    logic             redirect;
    logic [ADR_W-1:0] redirect_adr;
    logic             take;
    logic [7:0]       iram_data;
    logic [ADR_W-1:0] byte_adr;
    logic             waiting;
    logic             done;
    logic             mem_rd;
    logic [ADR_W-1:0] mem_adr;
    logic [7:0]       mem_data;
    logic             mem_valid;

    bytecode_fetcher #(.ADR_W(ADR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .start(start), .start_adr(start_adr),
        .end_adr(end_adr), .redirect(redirect), .redirect_adr(redirect_adr),
        .take(take), .iram_data(iram_data), .byte_adr(byte_adr),
        .waiting(waiting), .done(done), .mem_rd(mem_rd), .mem_adr(mem_adr),
        .mem_data(mem_data), .mem_valid(mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        int          ready;
    } req_t;

    typedef struct {
        logic [15:0] s;
        logic [15:0] e;
        int          lmin;
        int          lmax;
        bit          rnd_take;
        int          exp_reads;
    } vec_t;

    req_t        rq[$];
    vec_t        vecs[6];

    int          checks, errors, cyc;
    int          rd_total, vld_total, pops, max_out, last_ready;
    int          lat_min, lat_max, drop_cnt;
    bit          cnt_drop, want_first;
    logic [15:0] exp_adr, exp_fetch, first_adr;
    logic [7:0]  first_data;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h2A;
            16'h0011: return 8'h10;
            16'h0012: return 8'h3C;
            16'h0013: return 8'hB1;
            default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hC3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: memory answers, reads and pops are checked against the
    // expected streams, then time advances to the next falling edge.
    task automatic step();
        int o;
        int r;
        if (rq.size() > 0 && rq[0].ready <= cyc) begin
            mem_valid = 1'b1;
            mem_data  = mem_byte(rq[0].adr);
            void'(rq.pop_front());
        end else begin
            mem_valid = 1'b0;
            mem_data  = 8'($urandom);
        end
        if (cnt_drop && mem_rd && !redirect) cnt_drop = 1'b0;
        if (cnt_drop && mem_valid) drop_cnt++;
        o = rd_total - vld_total + int'(mem_rd);
        if (o > max_out) max_out = o;
        if (mem_rd) begin
            chk("mem_adr", mem_adr, exp_fetch);
            exp_fetch = exp_fetch + 16'd1;
            rd_total++;
            r = cyc + $urandom_range(lat_max, lat_min);
            if (r <= last_ready) r = last_ready + 1;
            last_ready = r;
            rq.push_back('{adr: mem_adr, ready: r});
        end
        if (mem_valid) vld_total++;
        if (take && !waiting && !redirect && !reset) begin
            chk("pop_byte_adr", byte_adr, exp_adr);
            chk("pop_iram_data", iram_data, mem_byte(exp_adr));
            if (want_first) begin
                first_adr  = byte_adr;
                first_data = iram_data;
                want_first = 1'b0;
            end
            exp_adr = exp_adr + 16'd1;
            pops++;
        end
        if (redirect && !reset) begin
            exp_adr   = redirect_adr;
            exp_fetch = redirect_adr;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] e);
        start     = 1'b1;
        start_adr = s;
        end_adr   = e;
        exp_adr   = s;
        exp_fetch = s;
        step();
        start     = 1'b0;
    endtask

    task automatic run_done(input bit rnd, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            take = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            step();
            n++;
        end
        take = 1'b0;
        chk("done_reached", done, 1);
    endtask

    initial begin
        int  n, r0, p0, v0;
        bit  found;

        vecs[0] = '{16'h0010, 16'h0014, 1, 1, 1'b0, 4};
        vecs[1] = '{16'h0020, 16'h0020, 1, 1, 1'b0, 0};
        vecs[2] = '{16'h0100, 16'h011F, 2, 2, 1'b1, 31};
        vecs[3] = '{16'h1000, 16'h1001, 3, 3, 1'b0, 1};
        vecs[4] = '{16'h0200, 16'h0240, 1, 4, 1'b1, 64};
        vecs[5] = '{16'h0300, 16'h0308, 5, 5, 1'b1, 8};

        checks = 0; errors = 0; cyc = 0;
        rd_total = 0; vld_total = 0; pops = 0; max_out = 0; last_ready = 0;
        lat_min = 1; lat_max = 1; drop_cnt = 0;
        cnt_drop = 1'b0; want_first = 1'b0;
        exp_adr = '0; exp_fetch = '0; first_adr = '0; first_data = '0;
        reset = 1'b1; start = 1'b0; start_adr = '0; end_adr = '0;
        redirect = 1'b0; redirect_adr = '0; take = 1'b0;
        mem_valid = 1'b0; mem_data = '0;

        // Reset, then idle
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        chk("rst_waiting", waiting, 1);
        chk("rst_done", done, 0);
        chk("rst_iram_data", iram_data, 0);
        chk("rst_byte_adr", byte_adr, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_adr", mem_adr, 0);
        r0 = rd_total;
        repeat (20) step();
        chk("idle_no_reads", rd_total - r0, 0);
        chk("idle_waiting", waiting, 1);
        chk("idle_done", done, 0);

        // Table of whole methods
        for (int i = 0; i < 6; i++) begin
            r0 = rd_total; p0 = pops; max_out = 0;
            lat_min = vecs[i].lmin; lat_max = vecs[i].lmax;
            do_start(vecs[i].s, vecs[i].e);
            run_done(vecs[i].rnd_take, 3000, n);
            chk("vec_reads", rd_total - r0, vecs[i].exp_reads);
            chk("vec_pops", pops - p0, vecs[i].exp_reads);
            chk("vec_max_outstanding_ok", max_out <= MAX_OUT, 1);
            chk("vec_waiting_in_done", waiting, 1);
            if (vecs[i].exp_reads == 0) chk("empty_done_within_2", n + 1 <= 2, 1);
        end

        // Take held low: credit stops reads once the FIFO is committed full
        lat_min = 3; lat_max = 3; max_out = 0;
        r0 = rd_total; p0 = pops;
        do_start(16'h0010, 16'h0030);
        repeat (30) step();
        chk("fill_reads", rd_total - r0, DEPTH);
        chk("fill_max_outstanding", max_out, MAX_OUT);
        chk("fill_waiting", waiting, 0);
        chk("fill_head_data", iram_data, 8'h2A);
        chk("fill_head_adr", byte_adr, 16'h0010);
        run_done(1'b0, 500, n);
        chk("fill_drain_pops", pops - p0, 32);
        chk("fill_total_reads", rd_total - r0, 32);

        // Redirect with two reads in flight
        lat_min = 3; lat_max = 3;
        do_start(16'h0030, 16'h0080);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rd_total - vld_total + int'(mem_rd) == 2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("redir_two_outstanding", found, 1);
        p0 = pops; want_first = 1'b1; cnt_drop = 1'b1; drop_cnt = 0;
        redirect = 1'b1; redirect_adr = 16'h0040;
        step();
        redirect = 1'b0;
        chk("redir_waiting", waiting, 1);
        run_done(1'b0, 1000, n);
        chk("redir_dropped", drop_cnt, 2);
        chk("redir_first_adr", first_adr, 16'h0040);
        chk("redir_first_data", first_data, mem_byte(16'h0040));
        chk("redir_pops", pops - p0, 16'h0040);

        // Redirect and take together with three bytes buffered
        lat_min = 1; lat_max = 1;
        do_start(16'h0010, 16'h0080);
        v0 = vld_total;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (vld_total - v0 == 3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("rt_three_buffered", found, 1);
        redirect = 1'b1; take = 1'b1; redirect_adr = 16'h0050;
        step();
        redirect = 1'b0; take = 1'b0;
        chk("rt_fifo_empty", waiting, 1);
        chk("rt_byte_adr", byte_adr, 16'h0050);
        chk("rt_iram_data", iram_data, 0);
        p0 = pops;
        run_done(1'b0, 1000, n);
        chk("rt_pops", pops - p0, 16'h0030);

        // Reset in the middle of a method
        lat_min = 3; lat_max = 3;
        do_start(16'h0010, 16'h0080);
        take = 1'b1;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0; take = 1'b0;
        chk("mid_rst_waiting", waiting, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_iram_data", iram_data, 0);
        chk("mid_rst_byte_adr", byte_adr, 0);
        chk("mid_rst_mem_rd", mem_rd, 0);
        chk("mid_rst_mem_adr", mem_adr, 0);
        r0 = rd_total;
        take = 1'b1;
        repeat (12) step();
        take = 1'b0;
        chk("late_resp_no_reads", rd_total - r0, 0);
        chk("late_resp_waiting", waiting, 1);
        chk("late_resp_done", done, 0);
        rq.delete();
        lat_min = 1; lat_max = 1;
        p0 = pops;
        do_start(16'h0020, 16'h0024);
        run_done(1'b0, 200, n);
        chk("recover_pops", pops - p0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
